dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (requester 0) and a debug/loader port (requester 1).
//  The pipeline has priority. A bounded-wait counter guarantees the debug port service and back-pressures the pipeline with cpu_stall.
//  A halt mode hands the port to the debug side indefinitely. Sits between the EX/MEM register outputs and the DataMemory instance.
// PARAMETERS
//  AW        6   word-address width (memory index = byte_addr[AW+1:2])
//  DW        32  data width
//  MAX_WAIT  4   max consecutive cycles a pending dbg_req may be denied (>=1)
// PORTS
//  clk           in   1   rising-edge clock, single domain
//  reset         in   1   synchronous, active-high
//  cpu_req       in   1   MEM stage access this cycle (MemRead_mem|MemWrite_mem)
//  cpu_we        in   1   MEM stage write
//  cpu_addr      in   AW  MEM stage word address
//  cpu_wdata     in   DW  MEM stage store data
//  cpu_rdata     out  DW  load data, combinational from mem_spo
//  cpu_stall     out  1   MEM stage must hold; access not performed this cycle
//  dbg_req       in   1   debug access request, held until dbg_gnt
//  dbg_we        in   1   debug write
//  dbg_addr      in   AW  debug word address
//  dbg_wdata     in   DW  debug store data
//  dbg_gnt       out  1   debug access performed this cycle (combinational)
//  dbg_rdata     out  DW  registered read data of the granted access
//  dbg_rvalid    out  1   1-cycle pulse, the cycle after a granted debug read
//  dbg_halt_req  in   1   request exclusive debug ownership
//  dbg_halted    out  1   exclusive ownership in effect
//  mem_a         out  AW  to DataMemory a
//  mem_d         out  DW  to DataMemory d
//  mem_we        out  1   to DataMemory we
//  mem_spo       in   DW  from DataMemory spo (async read)
// BEHAVIOUR
//  - FSM states: S_CPU (reset state), S_HALT.
//    S_CPU->S_HALT when dbg_halt_req=1. S_HALT->S_CPU when dbg_halt_req=0. Transitions take effect on the next edge.
//  - Owner each cycle (combinational):
//    - S_HALT: dbg.
//    - S_CPU: dbg if dbg_req & (!cpu_req | wait_cnt==MAX_WAIT); otherwise cpu.
//  - Memory drive: mem_a/mem_d come from the owner.
//    - mem_we = owner_we & owner_req & !reset.
//    - With no request: mem_we=0 and mem_a=cpu_addr.
//  - dbg_gnt = owner==dbg & dbg_req.
//  - cpu_stall = cpu_req & owner==dbg. In S_HALT, cpu_stall=cpu_req.
//  - wait_cnt (width clog2(MAX_WAIT+1)):
//    - Increments while dbg_req & !dbg_gnt, saturating at MAX_WAIT.
//    - Cleared on dbg_gnt or !dbg_req.
//  - Debug read latency is 1: on the edge after dbg_gnt & !dbg_we, dbg_rdata<=mem_spo and dbg_rvalid=1 for one cycle.
//    dbg_rdata holds its value otherwise.
//  - cpu_rdata = mem_spo always. It is valid only when cpu_req & !cpu_stall.
//  - dbg_halted=1 exactly while the state is S_HALT, registered.
//  - Simultaneous events:
//    - dbg_halt_req and dbg_req in S_CPU: the normal arbitration rule applies that cycle; halt takes effect next cycle.
//    - Halt exit with dbg_req pending: the next cycle is arbitrated under S_CPU rules with the current wait_cnt.
//  - Reset (including mid-access): state=S_CPU, wait_cnt=0, dbg_rdata=0, dbg_rvalid=0, dbg_halted=0. mem_we is forced 0 in the reset cycle.
//    The remaining outputs are combinational functions of inputs and state.
//  - Integration: cpu_stall must freeze PC, IF/ID, ID/EX and EX/MEM and bubble MEM/WB. A held access is retried unchanged.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined adds outputs stat_dbg_grants[15:0] and stat_cpu_stalls[15:0]:
//   - stat_dbg_grants increments per dbg_gnt cycle.
//   - stat_cpu_stalls increments per cpu_stall cycle.
//   - Both saturate at 16'hFFFF and clear on reset.
//  When undefined, the ports and counters do not exist and behaviour is otherwise identical.
// STRUCTURE
//  - Shared package/header: state encodings S_CPU=1'b0, S_HALT=1'b1; owner codes OWN_CPU/OWN_DBG; default widths AW/DW.
//  - One sub-module, arb_wait_counter: the saturating wait_cnt with inc/clr inputs and an at_max output.
//  - Everything else stays flat in dmem_arbiter.
// TESTING
//  1 Reset mid-write: cpu_req=1, cpu_we=1, reset=1 -> mem_we=0. After release: state S_CPU, dbg_rvalid=0, dbg_rdata=0.
//  2 Idle CPU, dbg read: dbg_req=1, dbg_we=0, addr=5, mem[5]=32'hDEADBEEF -> dbg_gnt same cycle.
//    Next cycle dbg_rvalid=1, dbg_rdata=32'hDEADBEEF.
//  3 Contention: cpu_req held 1, dbg_req=1 from cycle 0, MAX_WAIT=4 -> dbg_gnt and cpu_stall first at cycle 4.
//    wait_cnt returns to 0, and the CPU access proceeds at cycle 5.
//  4 Simultaneous write: cpu write addr 3 and dbg write addr 7 in the same cycle, wait_cnt=0 -> only mem[3] written, cpu_stall=0.
//    mem[7] is written on the later grant.
//  5 Halt: dbg_halt_req=1 with cpu_req=1 -> dbg_halted=1 next cycle and cpu_stall=1 throughout.
//    A dbg write to addr 2 lands. Drop halt -> dbg_halted=0 next cycle and the CPU proceeds.
//  6 With DMEM_ARB_STATS_EN: run scenario 3 twice -> stat_dbg_grants=2, stat_cpu_stalls=2. A forced 16'hFFFF value stays at 16'hFFFF.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// owner codes and default widths.
package dmem_arbiter_pkg;

  localparam int AW_DEF       = 6;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HALT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Width needed to hold the values 0..max_val
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_arb_wait_counter.sv
// Saturating counter of consecutive cycles a debug request has been denied.
// at_max tells the arbiter the debug side must win this cycle.
module arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt;

  // Count denied cycles, hold at the ceiling, clear on grant or withdrawal
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM
// stage (priority) and a debug/loader port, with a bounded wait for the
// debug side and an exclusive halt mode.
// Optional build macro: DMEM_ARB_STATS_EN adds saturating grant/stall
// statistics counters and their output ports.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  input  logic          dbg_halt_req,
  output logic          dbg_halted,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_dbg_grants,
  output logic [15:0]   stat_cpu_stalls
`endif
);

  arb_state_t state;
  owner_t     owner;
  logic       wait_at_max;
  logic       dbg_sel;

  // Halt FSM; dbg_halted is registered alongside the state it mirrors
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      dbg_halted <= 1'b0;
    end else begin
      case (state)
        S_CPU: begin
          if (dbg_halt_req) begin
            state      <= S_HALT;
            dbg_halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (!dbg_halt_req) begin
            state      <= S_CPU;
            dbg_halted <= 1'b0;
          end
        end
        default: begin
          state      <= S_CPU;
          dbg_halted <= 1'b0;
        end
      endcase
    end
  end

  // Owner selection: halt hands everything to debug; otherwise the CPU wins
  // unless it is idle or the debug side has waited its maximum
  always_comb begin
    // NOTE: default first so every path assigns owner and no latch is inferred.
    owner = OWN_CPU;
    if (state == S_HALT) begin
      owner = OWN_DBG;
    end else if (dbg_req && (!cpu_req || wait_at_max)) begin
      owner = OWN_DBG;
    end
  end

  // The debug side only drives the memory when it owns it and is asking
  assign dbg_sel   = (owner == OWN_DBG) && dbg_req;
  assign dbg_gnt   = dbg_sel;
  assign cpu_stall = cpu_req && (owner == OWN_DBG);

  assign mem_a  = dbg_sel ? dbg_addr  : cpu_addr;
  assign mem_d  = dbg_sel ? dbg_wdata : cpu_wdata;
  assign mem_we = !reset && (dbg_sel ? dbg_we : (cpu_req && cpu_we && (owner == OWN_CPU)));

  assign cpu_rdata = mem_spo;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (dbg_req && !dbg_gnt),
    .clr    (dbg_gnt || !dbg_req),
    .at_max (wait_at_max)
  );

  // Capture debug read data one cycle after the grant; hold it otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_spo;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating usage statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dbg_grants <= '0;
      stat_cpu_stalls <= '0;
    end else begin
      if (dbg_gnt && (stat_dbg_grants != 16'hFFFF)) begin
        stat_dbg_grants <= stat_dbg_grants + 16'd1;
      end
      if (cpu_stall && (stat_cpu_stalls != 16'hFFFF)) begin
        stat_cpu_stalls <= stat_cpu_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the arbiter
// and a reference copy of the memory.
module tb_dmem_arbiter;

  localparam int AW       = 6;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          dbg_halt_req = 1'b0;
  logic          dbg_halted;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_spo;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_dbg_grants, stat_cpu_stalls;
`endif

  // Bench-side memory standing in for DataMemory, with a preload path
  logic [DW-1:0] mem [DEPTH];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  // Reference memory contents
  logic [DW-1:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_spo = mem[mem_a];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_a] <= mem_d;
  end

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .dbg_halt_req(dbg_halt_req), .dbg_halted(dbg_halted),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
`ifdef DMEM_ARB_STATS_EN
    , .stat_dbg_grants(stat_dbg_grants), .stat_cpu_stalls(stat_cpu_stalls)
`endif
  );

  // Advance one clock; inputs change 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    reset = 1'b1;
    idle_inputs();
    bd_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 5) ? 32'hDEADBEEF : $urandom;
      bd_addr = AW'(i); bd_data = d; ref_mem[i] = d;
      tick();
    end
    bd_we = 1'b0;
    reset = 1'b0;
    tick();
    // debug read so the read-data register holds something before reset
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd9;
    tick();
    dbg_req = 1'b0;
    // reset in the middle of a CPU write
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd1; cpu_wdata = ~ref_mem[1];
    #2;
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we);
    end
    tick();
    reset = 1'b0;
    cpu_we = 1'b0;
    #2;
    n_tests++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== '0 || dbg_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: rvalid=%b rdata=%h halted=%b want 0/0/0", dbg_rvalid, dbg_rdata, dbg_halted);
    end
    n_tests++;
    if (mem[1] !== ref_mem[1]) begin
      n_fail++; $display("FAIL reset_no_write: mem[1]=%h want %h", mem[1], ref_mem[1]);
    end
    n_tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== ref_mem[1]) begin
      n_fail++; $display("FAIL reset_cpu_read: stall=%b rdata=%h want 0/%h", cpu_stall, cpu_rdata, ref_mem[1]);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_dbg_read();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    #2;
    n_tests++;
    if (dbg_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL dbg_read_gnt: gnt=%b we=%b want 1/0", dbg_gnt, mem_we);
    end
    tick();
    dbg_req = 1'b0;
    #2;
    n_tests++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL dbg_read_data: rvalid=%b rdata=%h want 1/deadbeef", dbg_rvalid, dbg_rdata);
    end
    tick();
    #2;
    n_tests++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL dbg_read_hold: rvalid=%b rdata=%h want 0/deadbeef", dbg_rvalid, dbg_rdata);
    end
  endtask

  task automatic test_contention();
    int fails;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd11;
    fails = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      n_tests++;
      if (dbg_gnt !== (c == 4) || cpu_stall !== (c == 4)) begin
        n_fail++; fails++;
        $display("FAIL contention_c%0d: gnt=%b stall=%b want %0d", c, dbg_gnt, cpu_stall, c == 4);
      end
      tick();
    end
    // cycle 5: CPU proceeds; a fresh debug request must wait the full bound again
    #2;
    n_tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== ref_mem[10] || dbg_rvalid !== 1'b1 || dbg_rdata !== ref_mem[11]) begin
      n_fail++;
      $display("FAIL contention_after: stall=%b rdata=%h rvalid=%b drdata=%h", cpu_stall, cpu_rdata, dbg_rvalid, dbg_rdata);
    end
    for (int c = 5; c < 10; c++) begin
      #2;
      n_tests++;
      if (dbg_gnt !== (c == 9)) begin
        n_fail++; $display("FAIL contention_rewait_c%0d: gnt=%b want %0d", c, dbg_gnt, c == 9);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_simul_write();
    logic [DW-1:0] a, b;
    a = ~ref_mem[3]; b = ~ref_mem[7];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd3; cpu_wdata = a;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd7; dbg_wdata = b;
    #2;
    n_tests++;
    if (cpu_stall !== 1'b0 || dbg_gnt !== 1'b0 || mem_we !== 1'b1 || mem_a !== 6'd3) begin
      n_fail++; $display("FAIL simul_cpu_wins: stall=%b gnt=%b we=%b a=%0d", cpu_stall, dbg_gnt, mem_we, mem_a);
    end
    tick();
    idle_inputs();
    dbg_req = 1'b1; dbg_we = 1'b1;
    #2;
    n_tests++;
    if (mem[3] !== a || mem[7] !== ref_mem[7] || dbg_gnt !== 1'b1) begin
      n_fail++; $display("FAIL simul_first: mem3=%h mem7=%h gnt=%b want %h %h 1", mem[3], mem[7], dbg_gnt, a, ref_mem[7]);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (mem[7] !== b) begin
      n_fail++; $display("FAIL simul_dbg_write: mem7=%h want %h", mem[7], b);
    end
    ref_mem[3] = a; ref_mem[7] = b;
  endtask

  task automatic test_halt();
    logic [DW-1:0] w1, w2, d;
    w1 = ~ref_mem[4]; w2 = w1 ^ 32'h5A5A_0001; d = ~ref_mem[2];
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd4; cpu_wdata = w1;
    dbg_halt_req = 1'b1;
    #2;
    n_tests++;
    if (dbg_halted !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL halt_request_cycle: halted=%b stall=%b want 0/0", dbg_halted, cpu_stall);
    end
    tick();
    cpu_wdata = w2;
    #2;
    n_tests++;
    if (dbg_halted !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL halt_entered: halted=%b stall=%b we=%b want 1/1/0", dbg_halted, cpu_stall, mem_we);
    end
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 6'd2; dbg_wdata = d;
    #2;
    n_tests++;
    if (dbg_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b1 || mem_a !== 6'd2) begin
      n_fail++; $display("FAIL halt_dbg_write: gnt=%b stall=%b we=%b a=%0d", dbg_gnt, cpu_stall, mem_we, mem_a);
    end
    tick();
    dbg_req = 1'b0;
    dbg_halt_req = 1'b0;
    #2;
    n_tests++;
    if (mem[2] !== d || dbg_halted !== 1'b1 || cpu_stall !== 1'b1 || mem[4] !== w1) begin
      n_fail++; $display("FAIL halt_exit_cycle: mem2=%h halted=%b stall=%b mem4=%h", mem[2], dbg_halted, cpu_stall, mem[4]);
    end
    tick();
    #2;
    n_tests++;
    if (dbg_halted !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL halt_left: halted=%b stall=%b we=%b want 0/0/1", dbg_halted, cpu_stall, mem_we);
    end
    tick();
    idle_inputs();
    #2;
    n_tests++;
    if (mem[4] !== w2) begin
      n_fail++; $display("FAIL halt_cpu_retry: mem4=%h want %h", mem[4], w2);
    end
    ref_mem[2] = d; ref_mem[4] = w2;
  endtask

  // Randomized traffic against a behavioural model: the debug side wins
  // when the CPU is idle, when halted, or once it has been refused
  // MAX_WAIT cycles in a row.
  task automatic test_random();
    int   waited;          // consecutive refused cycles of the pending debug request
    bit   halted_m;
    bit   exp_rvalid;
    logic [DW-1:0] exp_rdata;
    bit   last_gnt, last_stall;
    bit   dbg_wins, e_gnt, e_stall, e_we;
    int   errs;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
    idle_inputs();
    dbg_halt_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    waited = 0; halted_m = 0; exp_rvalid = 0; exp_rdata = '0;
    last_gnt = 0; last_stall = 0;
    errs = 0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      reset = ($urandom_range(99) == 0);
      if (!(cpu_req && last_stall)) begin
        cpu_req = ($urandom_range(3) != 0);
        cpu_we = $urandom_range(1) == 1;
        cpu_addr = AW'($urandom_range(DEPTH - 1));
        cpu_wdata = $urandom;
      end
      if (!(dbg_req && !last_gnt)) begin
        dbg_req = ($urandom_range(2) == 0);
        dbg_we = $urandom_range(1) == 1;
        dbg_addr = AW'($urandom_range(DEPTH - 1));
        dbg_wdata = $urandom;
      end
      if ($urandom_range(24) == 0) dbg_halt_req = !dbg_halt_req;
      #2;

      dbg_wins = halted_m || (dbg_req && (!cpu_req || waited >= MAX_WAIT));
      e_gnt    = dbg_wins && dbg_req;
      e_stall  = cpu_req && dbg_wins;
      e_we     = !reset && (e_gnt ? dbg_we : (cpu_req && cpu_we && !dbg_wins));

      n_tests++;
      if (dbg_gnt !== e_gnt || cpu_stall !== e_stall || mem_we !== e_we) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_arb cyc%0d: gnt=%b stall=%b we=%b want %b %b %b",
                   cyc, dbg_gnt, cpu_stall, mem_we, e_gnt, e_stall, e_we);
      end
      n_tests++;
      if (dbg_halted !== halted_m || dbg_rvalid !== exp_rvalid || dbg_rdata !== exp_rdata) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_regs cyc%0d: halted=%b rvalid=%b rdata=%h want %b %b %h",
                   cyc, dbg_halted, dbg_rvalid, dbg_rdata, halted_m, exp_rvalid, exp_rdata);
      end
      if (cpu_req && !e_stall && !cpu_we) begin
        n_tests++;
        if (cpu_rdata !== ref_mem[cpu_addr]) begin
          n_fail++; errs++;
          if (errs < 10)
            $display("FAIL rand_cpu_rdata cyc%0d: got %h want %h", cyc, cpu_rdata, ref_mem[cpu_addr]);
        end
      end

      // advance the model to the next cycle
      if (reset) begin
        waited = 0; halted_m = 0; exp_rvalid = 0; exp_rdata = '0;
      end else begin
        exp_rvalid = e_gnt && !dbg_we;
        if (exp_rvalid) exp_rdata = ref_mem[dbg_addr];
        waited   = (dbg_req && !e_gnt) ? waited + 1 : 0;
        halted_m = dbg_halt_req;
      end
      if (e_we) begin
        if (e_gnt) ref_mem[dbg_addr] = dbg_wdata;
        else       ref_mem[cpu_addr] = cpu_wdata;
      end
      last_gnt = e_gnt; last_stall = e_stall;
      tick();
    end
    reset = 1'b0;
    dbg_halt_req = 1'b0;
    idle_inputs();
    tick();
    #2;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (mem[i] !== ref_mem[i]) begin
        n_fail++; $display("FAIL rand_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    idle_inputs();
    dbg_halt_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    repeat (2) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd1;
      for (int c = 0; c < MAX_WAIT + 1; c++) tick();
      idle_inputs();
      tick();
    end
    #2;
    n_tests++;
    if (stat_dbg_grants !== 16'd2 || stat_cpu_stalls !== 16'd2) begin
      n_fail++; $display("FAIL stats_count: grants=%0d stalls=%0d want 2/2", stat_dbg_grants, stat_cpu_stalls);
    end
    dbg_halt_req = 1'b1;
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
    repeat (65540) tick();
    #2;
    n_tests++;
    if (stat_dbg_grants !== 16'hFFFF || stat_cpu_stalls !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_saturate: grants=%h stalls=%h want ffff", stat_dbg_grants, stat_cpu_stalls);
    end
    tick();
    #2;
    n_tests++;
    if (stat_dbg_grants !== 16'hFFFF || stat_cpu_stalls !== 16'hFFFF) begin
      n_fail++; $display("FAIL stats_hold: grants=%h stalls=%h want ffff", stat_dbg_grants, stat_cpu_stalls);
    end
    dbg_halt_req = 1'b0;
    idle_inputs();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_dbg_read();
    test_contention();
    test_simul_write();
    test_halt();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
